// File: rtl/bus_word_master.sv
// Word-to-byte bus initiator: splits one 32-bit request into byte beats, reassembles reads.
// Optional per-beat wait timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_word_master #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDRESS_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH*WORD_BYTES-1:0] req_wdata,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] resp_rdata,
  output logic                             resp_err,
  output logic                             bus_read,
  output logic                             bus_write,
  output logic [ADDRESS_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH-1:0]            bus_wdata,
  input  logic [DATA_WIDTH-1:0]            bus_rdata,
  input  logic                             bus_ready
);

  localparam int unsigned WordW = DATA_WIDTH * WORD_BYTES;
  localparam int unsigned BeatW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StGap, StResp} stateT;

  stateT                    stateQ, stateD;
  logic [BeatW-1:0]         beatQ, beatD;
  logic [ADDRESS_WIDTH-1:0] baseAddrQ, baseAddrD;
  logic                     writeQ, writeD;
  logic [WordW-1:0]         wdataQ, wdataD;
  logic [WordW-1:0]         rdataQ, rdataD;
  logic [ADDRESS_WIDTH-1:0] busAddrQ, busAddrD;
  logic                     busReadQ, busReadD;
  logic                     busWriteQ, busWriteD;
  logic [DATA_WIDTH-1:0]    busWdataQ, busWdataD;
  logic                     respValidQ, respValidD;
  logic                     reqReadyQ, reqReadyD;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned WaitW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Expiry fires on the TIMEOUT_CYCLES-th consecutive not-ready cycle of a beat.
  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TIMEOUT_CYCLES - 1);

  logic [WaitW-1:0] waitQ, waitD;
  logic             errQ, errD;
`endif

  always_comb begin
    stateD     = stateQ;
    beatD      = beatQ;
    baseAddrD  = baseAddrQ;
    writeD     = writeQ;
    wdataD     = wdataQ;
    rdataD     = rdataQ;
    busAddrD   = busAddrQ;
    busReadD   = 1'b0;
    busWriteD  = 1'b0;
    busWdataD  = '0;
    respValidD = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
    waitD      = waitQ;
    errD       = errQ;
`endif

    unique case (stateQ)
      StIdle: begin
        if (req_valid) begin
          baseAddrD = req_addr;
          writeD    = req_write;
          wdataD    = req_wdata;
          rdataD    = '0;
          beatD     = '0;
          stateD    = StAccess;
          busAddrD  = req_addr;
          busReadD  = ~req_write;
          busWriteD = req_write;
          busWdataD = req_write ? req_wdata[DATA_WIDTH-1:0] : '0;
`ifdef BUS_MASTER_TIMEOUT_EN
          waitD     = '0;
          errD      = 1'b0;
`endif
        end
      end

      StAccess: begin
        if (bus_ready) begin
          if (!writeQ) begin
            rdataD[int'(beatQ)*DATA_WIDTH +: DATA_WIDTH] = bus_rdata;
          end
          if (beatQ == LastBeat) begin
            stateD     = StResp;
            respValidD = 1'b1;
          end else begin
            beatD  = beatQ + 1'b1;
            stateD = StGap;
          end
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (waitQ == TimeoutLast) begin
          stateD     = StResp;
          respValidD = 1'b1;
          errD       = 1'b1;
        end
`endif
        else begin
          busReadD  = busReadQ;
          busWriteD = busWriteQ;
          busWdataD = busWdataQ;
`ifdef BUS_MASTER_TIMEOUT_EN
          waitD     = waitQ + 1'b1;
`endif
        end
      end

      StGap: begin
        // Beat index already advanced; address wraps modulo 2^ADDRESS_WIDTH.
        stateD    = StAccess;
        busAddrD  = baseAddrQ + ADDRESS_WIDTH'(beatQ);
        busReadD  = ~writeQ;
        busWriteD = writeQ;
        busWdataD = writeQ ? wdataQ[int'(beatQ)*DATA_WIDTH +: DATA_WIDTH] : '0;
`ifdef BUS_MASTER_TIMEOUT_EN
        waitD     = '0;
`endif
      end

      StResp: begin
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase

    reqReadyD = (stateD == StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= StIdle;
      beatQ      <= '0;
      baseAddrQ  <= '0;
      writeQ     <= 1'b0;
      wdataQ     <= '0;
      rdataQ     <= '0;
      busAddrQ   <= '0;
      busReadQ   <= 1'b0;
      busWriteQ  <= 1'b0;
      busWdataQ  <= '0;
      respValidQ <= 1'b0;
      reqReadyQ  <= 1'b1;
    end else begin
      stateQ     <= stateD;
      beatQ      <= beatD;
      baseAddrQ  <= baseAddrD;
      writeQ     <= writeD;
      wdataQ     <= wdataD;
      rdataQ     <= rdataD;
      busAddrQ   <= busAddrD;
      busReadQ   <= busReadD;
      busWriteQ  <= busWriteD;
      busWdataQ  <= busWdataD;
      respValidQ <= respValidD;
      reqReadyQ  <= reqReadyD;
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitQ <= '0;
      errQ  <= 1'b0;
    end else begin
      waitQ <= waitD;
      errQ  <= errD;
    end
  end

  assign resp_err = errQ;
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready  = reqReadyQ;
  assign resp_valid = respValidQ;
  assign resp_rdata = rdataQ;
  assign bus_read   = busReadQ;
  assign bus_write  = busWriteQ;
  assign bus_addr   = busAddrQ;
  assign bus_wdata  = busWdataQ;

endmodule
